// File: rtl/irl_tb_ctrl.sv
// irl_tb_ctrl: token-bucket engine of the ingress rate limiter.
module irl_tb_ctrl #(
    parameter int DEPTH_NBITS  = 4,
    parameter int TB_NBITS     = 24,
    parameter int FILL_NBITS   = 16,
    parameter int LEN_NBITS    = 14,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic [DEPTH_NBITS-1:0]  i_req_flow_id,
    input  logic [LEN_NBITS-1:0]    i_req_len,
    input  logic                    i_refill_tick,
    output logic                    o_token_bucket_rd,
    output logic [DEPTH_NBITS-1:0]  o_token_bucket_raddr,
    input  logic                    i_token_bucket_ack,
    input  logic [2*TB_NBITS-1:0]   i_token_bucket_rdata,
    output logic                    o_token_bucket_wr,
    output logic [DEPTH_NBITS-1:0]  o_token_bucket_waddr,
    output logic [2*TB_NBITS-1:0]   o_token_bucket_wdata,
    output logic                    o_fill_tb_src_rd,
    output logic [DEPTH_NBITS-1:0]  o_fill_tb_src_raddr,
    input  logic                    i_fill_tb_src_ack,
    input  logic [2*FILL_NBITS-1:0] i_fill_tb_src_rdata,
    output logic                    o_res_valid,
    output logic [1:0]              o_res_color,
    output logic [DEPTH_NBITS-1:0]  o_res_flow_id,
    output logic                    o_sweep_done,
    output logic                    o_refill_overrun,
    output logic [31:0]             o_stat_green_cnt,
    output logic [31:0]             o_stat_yellow_cnt,
    output logic [31:0]             o_stat_red_cnt
);
    localparam int SC_NBITS = $clog2(STARVE_LIMIT + 1);
    localparam logic [DEPTH_NBITS-1:0] LAST_IDX = '1;
    localparam logic [1:0] COL_GREEN  = 2'd0;
    localparam logic [1:0] COL_YELLOW = 2'd1;
    localparam logic [1:0] COL_RED    = 2'd2;

    typedef enum logic {S_IDLE, S_SWEEP} state_t;

    state_t                 r_state, w_state_nxt;
    logic [DEPTH_NBITS-1:0] r_idx, w_idx_nxt;
    logic [SC_NBITS-1:0]    r_starve, w_starve_nxt;
    logic                   r_alive;

    logic                   r_v1, r_pkt1, r_last1;
    logic [DEPTH_NBITS-1:0] r_addr1;
    logic [LEN_NBITS-1:0]   r_len1;
    logic                   r_fwd;
    logic [2*TB_NBITS-1:0]  r_wdata_q;
    logic                   r_res_valid;
    logic [1:0]             r_res_color;
    logic [DEPTH_NBITS-1:0] r_res_flow;

    logic                   w_sweep, w_force, w_pkt_issue, w_ref_issue, w_issue, w_ack;
    logic [DEPTH_NBITS-1:0] w_raddr;
    logic [2*TB_NBITS-1:0]  w_old, w_wdata;
    logic [TB_NBITS-1:0]    w_cir, w_eir, w_len, w_cir_new, w_eir_new;
    logic [TB_NBITS:0]      w_cir_sum, w_eir_sum;
    logic [1:0]             w_color;

    assign w_sweep     = (r_state == S_SWEEP);
    assign w_force     = w_sweep && (r_starve == SC_NBITS'(STARVE_LIMIT));
    assign o_req_ready = r_alive & ~w_force;
    assign w_pkt_issue = i_req_valid & o_req_ready;
    assign w_ref_issue = w_sweep & ~w_pkt_issue;
    assign w_issue     = w_pkt_issue | w_ref_issue;
    assign w_raddr     = w_pkt_issue ? i_req_flow_id : (w_ref_issue ? r_idx : '0);

    assign o_token_bucket_rd    = w_issue;
    assign o_token_bucket_raddr = w_raddr;
    assign o_fill_tb_src_rd     = w_ref_issue;
    assign o_fill_tb_src_raddr  = w_ref_issue ? r_idx : '0;
    assign o_refill_overrun     = w_sweep & i_refill_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_alive <= 1'b0;
        else        r_alive <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_starve <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_starve_nxt = '0;
        if (r_state == S_IDLE) begin
            if (i_refill_tick) begin
                w_state_nxt = S_SWEEP;
                w_idx_nxt   = '0;
            end
        end else begin
            if (i_req_valid && !w_force) w_starve_nxt = r_starve + 1'b1;
            if (w_ref_issue) begin
                w_idx_nxt = r_idx + 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_state_nxt  = S_IDLE;
                    w_starve_nxt = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_pkt1  <= 1'b0;
            r_last1 <= 1'b0;
            r_addr1 <= '0;
            r_len1  <= '0;
        end else begin
            r_v1    <= w_issue;
            r_pkt1  <= w_pkt_issue;
            r_last1 <= w_ref_issue && (r_idx == LAST_IDX);
            r_addr1 <= w_raddr;
            r_len1  <= w_pkt_issue ? i_req_len : '0;
        end
    end

    assign w_ack     = r_v1 & i_token_bucket_ack & (r_pkt1 | i_fill_tb_src_ack);
    assign w_old     = r_fwd ? r_wdata_q : i_token_bucket_rdata;
    assign w_cir     = w_old[2*TB_NBITS-1:TB_NBITS];
    assign w_eir     = w_old[TB_NBITS-1:0];
    assign w_len     = TB_NBITS'(r_len1);
    assign w_cir_sum = {1'b0, w_cir} + (TB_NBITS+1)'(i_fill_tb_src_rdata[2*FILL_NBITS-1:FILL_NBITS]);
    assign w_eir_sum = {1'b0, w_eir} + (TB_NBITS+1)'(i_fill_tb_src_rdata[FILL_NBITS-1:0]);

    always_comb begin
        w_color   = COL_RED;
        w_cir_new = w_cir;
        w_eir_new = w_eir;
        if (r_pkt1) begin
            if (w_len <= w_cir) begin
                w_color   = COL_GREEN;
                w_cir_new = w_cir - w_len;
            end else if (w_len <= w_eir) begin
                w_color   = COL_YELLOW;
                w_eir_new = w_eir - w_len;
            end
        end else begin
            w_cir_new = w_cir_sum[TB_NBITS] ? '1 : w_cir_sum[TB_NBITS-1:0];
            w_eir_new = w_eir_sum[TB_NBITS] ? '1 : w_eir_sum[TB_NBITS-1:0];
        end
    end

    assign w_wdata              = {w_cir_new, w_eir_new};
    assign o_token_bucket_wr    = w_ack;
    assign o_token_bucket_waddr = w_ack ? r_addr1 : '0;
    assign o_token_bucket_wdata = w_ack ? w_wdata : '0;
    assign o_sweep_done         = w_ack & ~r_pkt1 & r_last1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd       <= 1'b0;
            r_wdata_q   <= '0;
            r_res_valid <= 1'b0;
            r_res_color <= '0;
            r_res_flow  <= '0;
        end else begin
            r_fwd       <= w_ack & w_issue & (w_raddr == r_addr1);
            r_wdata_q   <= w_ack ? w_wdata : r_wdata_q;
            r_res_valid <= w_ack & r_pkt1;
            r_res_color <= (w_ack & r_pkt1) ? w_color : '0;
            r_res_flow  <= (w_ack & r_pkt1) ? r_addr1 : '0;
        end
    end

    assign o_res_valid   = r_res_valid;
    assign o_res_color   = r_res_color;
    assign o_res_flow_id = r_res_flow;

`ifdef IRL_TB_STATS_EN
    logic [31:0] r_green_cnt, r_yellow_cnt, r_red_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_green_cnt  <= '0;
            r_yellow_cnt <= '0;
            r_red_cnt    <= '0;
        end else if (r_res_valid) begin
            if (r_res_color == COL_GREEN && r_green_cnt != '1)   r_green_cnt  <= r_green_cnt + 1'b1;
            if (r_res_color == COL_YELLOW && r_yellow_cnt != '1) r_yellow_cnt <= r_yellow_cnt + 1'b1;
            if (r_res_color == COL_RED && r_red_cnt != '1)       r_red_cnt    <= r_red_cnt + 1'b1;
        end
    end

    assign o_stat_green_cnt  = r_green_cnt;
    assign o_stat_yellow_cnt = r_yellow_cnt;
    assign o_stat_red_cnt    = r_red_cnt;
`else
    assign o_stat_green_cnt  = '0;
    assign o_stat_yellow_cnt = '0;
    assign o_stat_red_cnt    = '0;
`endif

endmodule

// File: tb/tb_irl_tb_ctrl.sv
// tb_irl_tb_ctrl: directed self-checking bench for irl_tb_ctrl with RAM models.
module tb_irl_tb_ctrl;
    localparam int D = 4;
    localparam int T = 24;
    localparam int F = 16;
    localparam int L = 14;
`ifdef IRL_TB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           req_valid, req_ready, refill_tick;
    logic [D-1:0]   req_flow_id;
    logic [L-1:0]   req_len;
    logic           tb_rd, tb_ack, tb_wr, f_rd, f_ack;
    logic [D-1:0]   tb_raddr, tb_waddr, f_raddr, res_flow;
    logic [2*T-1:0] tb_rdata, tb_wdata;
    logic [2*F-1:0] f_rdata;
    logic           res_valid, sweep_done, overrun;
    logic [1:0]     res_color;
    logic [31:0]    st_g, st_y, st_r;

    irl_tb_ctrl #(.DEPTH_NBITS(D), .TB_NBITS(T), .FILL_NBITS(F), .LEN_NBITS(L), .STARVE_LIMIT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_flow_id(req_flow_id), .i_req_len(req_len), .i_refill_tick(refill_tick),
        .o_token_bucket_rd(tb_rd), .o_token_bucket_raddr(tb_raddr),
        .i_token_bucket_ack(tb_ack), .i_token_bucket_rdata(tb_rdata),
        .o_token_bucket_wr(tb_wr), .o_token_bucket_waddr(tb_waddr), .o_token_bucket_wdata(tb_wdata),
        .o_fill_tb_src_rd(f_rd), .o_fill_tb_src_raddr(f_raddr),
        .i_fill_tb_src_ack(f_ack), .i_fill_tb_src_rdata(f_rdata),
        .o_res_valid(res_valid), .o_res_color(res_color), .o_res_flow_id(res_flow),
        .o_sweep_done(sweep_done), .o_refill_overrun(overrun),
        .o_stat_green_cnt(st_g), .o_stat_yellow_cnt(st_y), .o_stat_red_cnt(st_r)
    );

    // RAM models: read-during-write returns old data; backdoor load port.
    logic [2*T-1:0] mem [16];
    logic [2*F-1:0] fmem [16];
    logic           ld_en = 1'b0, ld_fill = 1'b0;
    logic [3:0]     ld_addr = '0;
    logic [2*T-1:0] ld_data = '0;
    always @(posedge clk) begin
        tb_ack <= tb_rd;
        if (tb_rd) tb_rdata <= mem[tb_raddr];
        if (tb_wr) mem[tb_waddr] <= tb_wdata;
        f_ack <= f_rd;
        if (f_rd) f_rdata <= fmem[f_raddr];
        if (ld_en && ld_fill) fmem[ld_addr] <= ld_data[2*F-1:0];
        if (ld_en && !ld_fill) mem[ld_addr] <= ld_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    logic [51:0] wr_q[$];
    int          wr_cyc_q[$];
    logic [5:0]  res_q[$];
    int          res_cyc_q[$];
    int fill_n, first_fill, done_n, done_cyc, ovr_n, rst_wr_n, low_n, run;
    logic mon_starve = 1'b0;

    // Event logger sampled mid-cycle.
    always @(negedge clk) begin
        if (tb_wr) begin
            wr_q.push_back({tb_waddr, tb_wdata});
            wr_cyc_q.push_back(cyc);
        end
        if (res_valid) begin
            res_q.push_back({res_color, res_flow});
            res_cyc_q.push_back(cyc);
        end
        if (f_rd) begin
            if (fill_n == 0) first_fill = cyc;
            fill_n++;
        end
        if (sweep_done) begin
            done_n++;
            done_cyc = cyc;
        end
        if (overrun) ovr_n++;
        if (!rst_n && tb_wr) rst_wr_n++;
        if (mon_starve && rst_n) begin
            if (!req_ready) begin
                low_n++;
                check("starve_run", run, 16);
                run = 0;
            end else run++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic fill, input logic [3:0] a, input logic [2*T-1:0] d);
        ld_en = 1'b1; ld_fill = fill; ld_addr = a; ld_data = d;
        step(1);
        ld_en = 1'b0;
    endtask

    task automatic clear_logs();
        wr_q.delete(); wr_cyc_q.delete(); res_q.delete(); res_cyc_q.delete();
        fill_n = 0; done_n = 0; ovr_n = 0; low_n = 0; run = 0; rst_wr_n = 0;
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget && done_n == 0; k++) step(1);
    endtask

    int i0, t0, bad, fill_before;

    initial begin
        req_valid = 0; req_flow_id = '0; req_len = '0; refill_tick = 0;
        clear_logs();
        #12;
        check("rst_ready", req_ready, 0);
        check("rst_rd", tb_rd, 0);
        check("rst_wr", tb_wr, 0);
        check("rst_fill_rd", f_rd, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_done", sweep_done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1);
        check("ready_after_rst", req_ready, 1);
        check("idle_no_rd", tb_rd, 0);

        // Back-to-back on flow 5: green, yellow via forwarded word, red.
        load(0, 4'd5, {24'd1000, 24'd500});
        clear_logs();
        i0 = cyc;
        req_valid = 1; req_flow_id = 4'd5; req_len = 14'd800;
        step(1); req_len = 14'd300;
        step(1); req_len = 14'd800;
        step(1); req_valid = 0;
        step(4);
        check("a_wr_n", wr_q.size(), 3);
        check("a_wr0", wr_q[0], {4'd5, 24'd200, 24'd500});
        check("a_wr1", wr_q[1], {4'd5, 24'd200, 24'd200});
        check("a_wr2", wr_q[2], {4'd5, 24'd200, 24'd200});
        check("a_wr_lat", wr_cyc_q[0], i0 + 1);
        check("a_res_n", res_q.size(), 3);
        check("a_res0", res_q[0], {2'd0, 4'd5});
        check("a_res1", res_q[1], {2'd1, 4'd5});
        check("a_res2", res_q[2], {2'd2, 4'd5});
        check("a_res_lat", res_cyc_q[0], i0 + 2);

        // Bucket {100,50}: equality is green, then yellow, then red.
        load(0, 4'd7, {24'd100, 24'd50});
        clear_logs();
        req_valid = 1; req_flow_id = 4'd7; req_len = 14'd100;
        step(1); req_len = 14'd1;
        step(1); req_len = 14'd60;
        step(1); req_valid = 0;
        step(4);
        check("b_wr_n", wr_q.size(), 3);
        check("b_wr0", wr_q[0], {4'd7, 24'd0, 24'd50});
        check("b_wr1", wr_q[1], {4'd7, 24'd0, 24'd49});
        check("b_wr2", wr_q[2], {4'd7, 24'd0, 24'd49});
        check("b_res0", res_q[0], {2'd0, 4'd7});
        check("b_res1", res_q[1], {2'd1, 4'd7});
        check("b_res2", res_q[2], {2'd2, 4'd7});
        check("stat_green", st_g, STATS ? 2 : 0);
        check("stat_yellow", st_y, STATS ? 2 : 0);
        check("stat_red", st_r, STATS ? 2 : 0);

        // Idle sweep with saturation and an overrun tick mid-sweep.
        for (int a = 0; a < 16; a++) begin
            load(0, 4'(a), {24'hFFFFFB, 24'd0});
            load(1, 4'(a), 48'({16'd10, 16'd20}));
        end
        clear_logs();
        t0 = cyc;
        refill_tick = 1;
        step(1); refill_tick = 0;
        step(4); refill_tick = 1;
        step(1); refill_tick = 0;
        wait_done(60);
        step(4);
        check("c_done_n", done_n, 1);
        check("c_first_issue", first_fill, t0 + 1);
        check("c_done_lat", done_cyc, first_fill + 16);
        check("c_fill_n", fill_n, 16);
        check("c_overrun_n", ovr_n, 1);
        check("c_wr_n", wr_q.size(), 16);
        bad = 0;
        for (int a = 0; a < 16; a++)
            if (wr_q[a] !== {4'(a), 24'hFFFFFF, 24'd20}) bad++;
        check("c_wr_bad", bad, 0);
        check("c_wr15", wr_q[15], {4'd15, 24'hFFFFFF, 24'd20});
        check("c_no_res", res_q.size(), 0);

        // Continuous requests during a sweep: guard forces one slot per 16.
        for (int a = 0; a < 16; a++) begin
            load(0, 4'(a), {24'd100, 24'd100});
            load(1, 4'(a), 48'({16'd1, 16'd2}));
        end
        clear_logs();
        refill_tick = 1;
        step(1);
        refill_tick = 0; req_valid = 1; req_flow_id = 4'd0; req_len = 14'd0;
        mon_starve = 1'b1;
        wait_done(400);
        step(1);
        mon_starve = 1'b0; req_valid = 0;
        step(4);
        check("e_low_n", low_n, 16);
        check("e_done_n", done_n, 1);
        check("e_fill_n", fill_n, 16);
        check("e_mem0", mem[0], {24'd101, 24'd102});
        check("e_mem9", mem[9], {24'd101, 24'd102});

        // Reset asserted mid-sweep.
        clear_logs();
        refill_tick = 1;
        step(1); refill_tick = 0;
        step(5);
        rst_n = 1'b0; req_valid = 1; req_flow_id = 4'd3; req_len = 14'd5; refill_tick = 1;
        #2;
        check("f_rst_ready", req_ready, 0);
        check("f_rst_rd", tb_rd, 0);
        check("f_rst_fill_rd", f_rd, 0);
        check("f_rst_wr", tb_wr, 0);
        check("f_rst_wdata", tb_wdata, 0);
        check("f_rst_overrun", overrun, 0);
        check("f_rst_res", res_valid, 0);
        step(3);
        check("f_rst_no_wr", rst_wr_n, 0);
        req_valid = 0; refill_tick = 0;
        rst_n = 1'b1;
        fill_before = fill_n;
        step(6);
        check("f_idle_after_rst", fill_n, fill_before);
        check("f_stat_green", st_g, 0);
        check("f_done_none", done_n, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
